// File: rtl/alu_issue_queue.sv
// Eight-entry (parameterisable) compacting issue queue for the integer ALU.
// Entries age from index 0 (oldest) upward; the oldest ready entry is issued each cycle.
module alu_issue_queue #(
  parameter int DEPTH = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Dis_IntIssueEn,
  input  logic [2:0]  Dis_Opcode,
  input  logic [4:0]  Dis_RobTag,
  input  logic [5:0]  Dis_RdPhyAddr,
  input  logic [5:0]  Dis_RsPhyAddr,
  input  logic [5:0]  Dis_RtPhyAddr,
  input  logic        Dis_RsReady,
  input  logic        Dis_RtReady,
  input  logic        Dis_RegWrite,
  input  logic        Dis_Branch,
  input  logic        Dis_BranchPredict,
  input  logic        Dis_JalInst,
  input  logic        Dis_JrInst,
  input  logic        Dis_JrRsInst,
  input  logic [31:0] Dis_BranchAddr,
  input  logic [2:0]  Dis_BranchUptAddr,
  input  logic [15:0] Dis_Immediate,
  output logic        Iss_IntQueueFull,
  input  logic        Wb_Valid,
  input  logic [5:0]  Wb_PhyAddr,
  input  logic        Cdb_Flush,
  input  logic [4:0]  Cdb_RobDepth,
  input  logic [4:0]  Rob_TopPtr,
  input  logic        Alu_Stall,
  output logic        Iss_ValidAlu,
  output logic [5:0]  Iss_RsPhyAddrAlu,
  output logic [5:0]  Iss_RtPhyAddrAlu,
  output logic [2:0]  Iss_OpcodeAlu,
  output logic [4:0]  Iss_RobTagAlu,
  output logic [5:0]  Iss_RdPhyAddrAlu,
  output logic [31:0] Iss_BranchAddrAlu,
  output logic        Iss_BranchAlu,
  output logic        Iss_RegWriteAlu,
  output logic [2:0]  Iss_BranchUptAddrAlu,
  output logic        Iss_BranchPredictAlu,
  output logic        Iss_JalInstAlu,
  output logic        Iss_JrInstAlu,
  output logic        Iss_JrRsInstAlu,
  output logic [15:0] Iss_ImmediateAlu
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  typedef struct packed {
    logic        valid;
    logic        rs_rdy;
    logic        rt_rdy;
    logic [5:0]  rs_tag;
    logic [5:0]  rt_tag;
    logic [2:0]  opcode;
    logic [4:0]  rob_tag;
    logic [5:0]  rd_tag;
    logic        reg_write;
    logic        branch;
    logic        branch_predict;
    logic        jal;
    logic        jr;
    logic        jr_rs;
    logic [31:0] branch_addr;
    logic [2:0]  branch_upt;
    logic [15:0] imm;
  } entry_t;

  entry_t          q_q   [DEPTH];
  entry_t          q_d   [DEPTH];
  entry_t          woken [DEPTH];
  logic [DEPTH-1:0] keep;
  logic            full_q;
  logic            full_d;
  logic [CW-1:0]   count_d;

  logic            found;
  logic [IW-1:0]   sel_idx;
  entry_t          sel_entry;
  logic            issue;
  logic            dis_accept;
  entry_t          new_entry;

  assign issue      = found && !Alu_Stall && !Cdb_Flush;
  assign dis_accept = Dis_IntIssueEn && !full_q && !Cdb_Flush;

  // Wakeup and survival are evaluated per entry; the issued entry and any
  // entry younger than the flushing instruction do not survive the edge.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [4:0] age;
      logic       flushed;
      logic       issued;

      assign age     = q_q[gi].rob_tag - Rob_TopPtr;
      assign flushed = Cdb_Flush && (age > Cdb_RobDepth);
      assign issued  = issue && (sel_idx == IW'(gi));
      assign keep[gi] = q_q[gi].valid && !flushed && !issued;

      always_comb begin
        woken[gi] = q_q[gi];
        if (Wb_Valid && (Wb_PhyAddr == q_q[gi].rs_tag)) woken[gi].rs_rdy = 1'b1;
        if (Wb_Valid && (Wb_PhyAddr == q_q[gi].rt_tag)) woken[gi].rt_rdy = 1'b1;
      end
    end
  endgenerate

  // Oldest-first select on registered ready bits only.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (q_q[i].valid && q_q[i].rs_rdy && q_q[i].rt_rdy) begin
        found   = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end

  always_comb begin
    new_entry                = '0;
    new_entry.valid          = 1'b1;
    new_entry.rs_rdy         = Dis_RsReady || (Wb_Valid && (Wb_PhyAddr == Dis_RsPhyAddr));
    new_entry.rt_rdy         = Dis_RtReady || (Wb_Valid && (Wb_PhyAddr == Dis_RtPhyAddr));
    new_entry.rs_tag         = Dis_RsPhyAddr;
    new_entry.rt_tag         = Dis_RtPhyAddr;
    new_entry.opcode         = Dis_Opcode;
    new_entry.rob_tag        = Dis_RobTag;
    new_entry.rd_tag         = Dis_RdPhyAddr;
    new_entry.reg_write      = Dis_RegWrite;
    new_entry.branch         = Dis_Branch;
    new_entry.branch_predict = Dis_BranchPredict;
    new_entry.jal            = Dis_JalInst;
    new_entry.jr             = Dis_JrInst;
    new_entry.jr_rs          = Dis_JrRsInst;
    new_entry.branch_addr    = Dis_BranchAddr;
    new_entry.branch_upt     = Dis_BranchUptAddr;
    new_entry.imm            = Dis_Immediate;
  end

  // Survivors pack down in age order; a dispatch lands right after them.
  // The slot index never exceeds the number of older survivors, so it stays in range.
  always_comb begin
    logic [CW-1:0] kept;
    kept = '0;
    for (int j = 0; j < DEPTH; j++) q_d[j] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (keep[i]) begin
        q_d[kept[IW-1:0]] = woken[i];
        kept              = kept + CW'(1);
      end
    end
    if (dis_accept && (kept < CW'(DEPTH))) q_d[kept[IW-1:0]] = new_entry;
    count_d = kept + CW'(dis_accept);
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
      full_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q_q[i] <= q_d[i];
      full_q <= full_d;
    end
  end

  assign sel_entry = found ? q_q[sel_idx] : '0;

  assign Iss_IntQueueFull     = full_q;
  assign Iss_ValidAlu         = issue;
  assign Iss_RsPhyAddrAlu     = sel_entry.rs_tag;
  assign Iss_RtPhyAddrAlu     = sel_entry.rt_tag;
  assign Iss_OpcodeAlu        = sel_entry.opcode;
  assign Iss_RobTagAlu        = sel_entry.rob_tag;
  assign Iss_RdPhyAddrAlu     = sel_entry.rd_tag;
  assign Iss_BranchAddrAlu    = sel_entry.branch_addr;
  assign Iss_BranchAlu        = sel_entry.branch;
  assign Iss_RegWriteAlu      = sel_entry.reg_write;
  assign Iss_BranchUptAddrAlu = sel_entry.branch_upt;
  assign Iss_BranchPredictAlu = sel_entry.branch_predict;
  assign Iss_JalInstAlu       = sel_entry.jal;
  assign Iss_JrInstAlu        = sel_entry.jr;
  assign Iss_JrRsInstAlu      = sel_entry.jr_rs;
  assign Iss_ImmediateAlu     = sel_entry.imm;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed self-checking bench for alu_issue_queue.
module tb_alu_issue_queue;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Dis_IntIssueEn;
  logic [2:0]  Dis_Opcode;
  logic [4:0]  Dis_RobTag;
  logic [5:0]  Dis_RdPhyAddr;
  logic [5:0]  Dis_RsPhyAddr;
  logic [5:0]  Dis_RtPhyAddr;
  logic        Dis_RsReady;
  logic        Dis_RtReady;
  logic        Dis_RegWrite;
  logic        Dis_Branch;
  logic        Dis_BranchPredict;
  logic        Dis_JalInst;
  logic        Dis_JrInst;
  logic        Dis_JrRsInst;
  logic [31:0] Dis_BranchAddr;
  logic [2:0]  Dis_BranchUptAddr;
  logic [15:0] Dis_Immediate;
  logic        Iss_IntQueueFull;
  logic        Wb_Valid;
  logic [5:0]  Wb_PhyAddr;
  logic        Cdb_Flush;
  logic [4:0]  Cdb_RobDepth;
  logic [4:0]  Rob_TopPtr;
  logic        Alu_Stall;
  logic        Iss_ValidAlu;
  logic [5:0]  Iss_RsPhyAddrAlu;
  logic [5:0]  Iss_RtPhyAddrAlu;
  logic [2:0]  Iss_OpcodeAlu;
  logic [4:0]  Iss_RobTagAlu;
  logic [5:0]  Iss_RdPhyAddrAlu;
  logic [31:0] Iss_BranchAddrAlu;
  logic        Iss_BranchAlu;
  logic        Iss_RegWriteAlu;
  logic [2:0]  Iss_BranchUptAddrAlu;
  logic        Iss_BranchPredictAlu;
  logic        Iss_JalInstAlu;
  logic        Iss_JrInstAlu;
  logic        Iss_JrRsInstAlu;
  logic [15:0] Iss_ImmediateAlu;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  alu_issue_queue #(.DEPTH(8)) dut (
    .Clk(Clk), .Reset(Reset),
    .Dis_IntIssueEn(Dis_IntIssueEn), .Dis_Opcode(Dis_Opcode), .Dis_RobTag(Dis_RobTag),
    .Dis_RdPhyAddr(Dis_RdPhyAddr), .Dis_RsPhyAddr(Dis_RsPhyAddr), .Dis_RtPhyAddr(Dis_RtPhyAddr),
    .Dis_RsReady(Dis_RsReady), .Dis_RtReady(Dis_RtReady), .Dis_RegWrite(Dis_RegWrite),
    .Dis_Branch(Dis_Branch), .Dis_BranchPredict(Dis_BranchPredict), .Dis_JalInst(Dis_JalInst),
    .Dis_JrInst(Dis_JrInst), .Dis_JrRsInst(Dis_JrRsInst), .Dis_BranchAddr(Dis_BranchAddr),
    .Dis_BranchUptAddr(Dis_BranchUptAddr), .Dis_Immediate(Dis_Immediate),
    .Iss_IntQueueFull(Iss_IntQueueFull), .Wb_Valid(Wb_Valid), .Wb_PhyAddr(Wb_PhyAddr),
    .Cdb_Flush(Cdb_Flush), .Cdb_RobDepth(Cdb_RobDepth), .Rob_TopPtr(Rob_TopPtr),
    .Alu_Stall(Alu_Stall), .Iss_ValidAlu(Iss_ValidAlu),
    .Iss_RsPhyAddrAlu(Iss_RsPhyAddrAlu), .Iss_RtPhyAddrAlu(Iss_RtPhyAddrAlu),
    .Iss_OpcodeAlu(Iss_OpcodeAlu), .Iss_RobTagAlu(Iss_RobTagAlu),
    .Iss_RdPhyAddrAlu(Iss_RdPhyAddrAlu), .Iss_BranchAddrAlu(Iss_BranchAddrAlu),
    .Iss_BranchAlu(Iss_BranchAlu), .Iss_RegWriteAlu(Iss_RegWriteAlu),
    .Iss_BranchUptAddrAlu(Iss_BranchUptAddrAlu), .Iss_BranchPredictAlu(Iss_BranchPredictAlu),
    .Iss_JalInstAlu(Iss_JalInstAlu), .Iss_JrInstAlu(Iss_JrInstAlu),
    .Iss_JrRsInstAlu(Iss_JrRsInstAlu), .Iss_ImmediateAlu(Iss_ImmediateAlu)
  );

  // The dispatch unit never writes into a full queue.
  always @(posedge Clk) begin
    if (!Reset) assert (!(Dis_IntIssueEn && Iss_IntQueueFull)) else $error("dispatch while full");
  end

  task automatic idle();
    Dis_IntIssueEn = 0; Dis_Opcode = 0; Dis_RobTag = 0; Dis_RdPhyAddr = 0;
    Dis_RsPhyAddr = 0; Dis_RtPhyAddr = 0; Dis_RsReady = 0; Dis_RtReady = 0;
    Dis_RegWrite = 0; Dis_Branch = 0; Dis_BranchPredict = 0; Dis_JalInst = 0;
    Dis_JrInst = 0; Dis_JrRsInst = 0; Dis_BranchAddr = 0; Dis_BranchUptAddr = 0;
    Dis_Immediate = 0;
  endtask

  task automatic set_dis(input logic [4:0] rob, input logic [5:0] rs, input logic [5:0] rt,
                         input logic rsr, input logic rtr);
    Dis_IntIssueEn = 1; Dis_RobTag = rob; Dis_RsPhyAddr = rs; Dis_RtPhyAddr = rt;
    Dis_RsReady = rsr; Dis_RtReady = rtr;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1; idle(); Wb_Valid = 0; Wb_PhyAddr = 0; Cdb_Flush = 0; Cdb_RobDepth = 0;
    Rob_TopPtr = 0; Alu_Stall = 0;
    repeat (2) @(posedge Clk);
    #1;
    checks++; if (Iss_IntQueueFull !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", Iss_IntQueueFull); end
    checks++; if (Iss_ValidAlu !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", Iss_ValidAlu); end
    checks++; if ({Iss_RobTagAlu, Iss_ImmediateAlu, Iss_BranchAddrAlu} !== 53'd0) begin errors++; $display("FAIL reset_payload: got %h expected 0", {Iss_RobTagAlu, Iss_ImmediateAlu, Iss_BranchAddrAlu}); end
    Reset = 0;
    step();
  endtask

  task automatic test_single();
    set_dis(5'd3, 6'd1, 6'd2, 1, 1);
    Dis_Opcode = 3'd5; Dis_RdPhyAddr = 6'd7; Dis_RegWrite = 1; Dis_JalInst = 1;
    Dis_BranchAddr = 32'h1234_5678; Dis_BranchUptAddr = 3'd6; Dis_Immediate = 16'hBEEF;
    step();
    idle(); #1;
    checks++; if (Iss_ValidAlu !== 1'b1 || Iss_RobTagAlu !== 5'd3) begin errors++; $display("FAIL single_issue: got valid %b tag %0d expected 1 tag 3", Iss_ValidAlu, Iss_RobTagAlu); end
    checks++; if ({Iss_OpcodeAlu, Iss_RdPhyAddrAlu, Iss_RsPhyAddrAlu, Iss_RtPhyAddrAlu} !== {3'd5, 6'd7, 6'd1, 6'd2}) begin errors++; $display("FAIL single_regs: got op %0d rd %0d rs %0d rt %0d expected 5 7 1 2", Iss_OpcodeAlu, Iss_RdPhyAddrAlu, Iss_RsPhyAddrAlu, Iss_RtPhyAddrAlu); end
    checks++; if ({Iss_BranchAddrAlu, Iss_ImmediateAlu, Iss_BranchUptAddrAlu} !== {32'h1234_5678, 16'hBEEF, 3'd6}) begin errors++; $display("FAIL single_fields: got %h %h %0d expected 12345678 beef 6", Iss_BranchAddrAlu, Iss_ImmediateAlu, Iss_BranchUptAddrAlu); end
    checks++; if ({Iss_RegWriteAlu, Iss_JalInstAlu, Iss_BranchAlu, Iss_JrInstAlu} !== 4'b1100) begin errors++; $display("FAIL single_flags: got %b expected 1100", {Iss_RegWriteAlu, Iss_JalInstAlu, Iss_BranchAlu, Iss_JrInstAlu}); end
    step();
    checks++; if (Iss_ValidAlu !== 1'b0 || Iss_RobTagAlu !== 5'd0) begin errors++; $display("FAIL single_empty: got valid %b tag %0d expected 0 0", Iss_ValidAlu, Iss_RobTagAlu); end
    $display("single dispatch/issue done");
  endtask

  task automatic test_wakeup_order();
    set_dis(5'd1, 6'd10, 6'd11, 0, 1);
    step();
    set_dis(5'd2, 6'd12, 6'd13, 1, 1);
    step();
    idle(); #1;
    checks++; if (Iss_ValidAlu !== 1'b1 || Iss_RobTagAlu !== 5'd2) begin errors++; $display("FAIL order_young_first: got valid %b tag %0d expected 1 tag 2", Iss_ValidAlu, Iss_RobTagAlu); end
    step();
    Wb_Valid = 1; Wb_PhyAddr = 6'd10; #1;
    checks++; if (Iss_ValidAlu !== 1'b0) begin errors++; $display("FAIL wake_no_bypass: got %b expected 0", Iss_ValidAlu); end
    step();
    Wb_Valid = 0; #1;
    checks++; if (Iss_ValidAlu !== 1'b1 || Iss_RobTagAlu !== 5'd1) begin errors++; $display("FAIL wake_issue: got valid %b tag %0d expected 1 tag 1", Iss_ValidAlu, Iss_RobTagAlu); end
    step();
    checks++; if (Iss_ValidAlu !== 1'b0) begin errors++; $display("FAIL wake_empty: got %b expected 0", Iss_ValidAlu); end
    $display("wakeup ordering done");
  endtask

  task automatic test_full();
    int wake_tags [7] = '{20, 21, 23, 24, 25, 26, 27};
    int exp_order [7] = '{1, 3, 4, 5, 6, 7, 9};
    for (int i = 0; i < 8; i++) begin
      set_dis(5'(i), 6'(20 + i), 6'd60, 0, 1);
      step();
    end
    idle(); #1;
    checks++; if (Iss_IntQueueFull !== 1'b1 || Iss_ValidAlu !== 1'b0) begin errors++; $display("FAIL full_set: got full %b valid %b expected 1 0", Iss_IntQueueFull, Iss_ValidAlu); end
    Wb_Valid = 1; Wb_PhyAddr = 6'd22;
    step();
    Wb_Valid = 0; #1;
    checks++; if (Iss_ValidAlu !== 1'b1 || Iss_RobTagAlu !== 5'd2 || Iss_IntQueueFull !== 1'b1) begin errors++; $display("FAIL full_mid_issue: got valid %b tag %0d full %b expected 1 2 1", Iss_ValidAlu, Iss_RobTagAlu, Iss_IntQueueFull); end
    step();
    checks++; if (Iss_IntQueueFull !== 1'b0) begin errors++; $display("FAIL full_drop: got %b expected 0", Iss_IntQueueFull); end
    Alu_Stall = 1;
    for (int i = 0; i < 7; i++) begin
      Wb_Valid = 1; Wb_PhyAddr = 6'(wake_tags[i]);
      step();
    end
    Wb_Valid = 0; #1;
    checks++; if (Iss_ValidAlu !== 1'b0 || Iss_RobTagAlu !== 5'd0) begin errors++; $display("FAIL full_stall_hold: got valid %b tag %0d expected 0 0", Iss_ValidAlu, Iss_RobTagAlu); end
    Alu_Stall = 0;
    set_dis(5'd9, 6'd0, 6'd0, 1, 1); #1;
    checks++; if (Iss_ValidAlu !== 1'b1 || Iss_RobTagAlu !== 5'd0) begin errors++; $display("FAIL full_simul_issue: got valid %b tag %0d expected 1 0", Iss_ValidAlu, Iss_RobTagAlu); end
    step();
    idle(); #1;
    checks++; if (Iss_IntQueueFull !== 1'b0) begin errors++; $display("FAIL full_simul_count: got full %b expected 0", Iss_IntQueueFull); end
    for (int i = 0; i < 7; i++) begin
      checks++; if (Iss_ValidAlu !== 1'b1 || Iss_RobTagAlu !== 5'(exp_order[i])) begin errors++; $display("FAIL full_drain_%0d: got valid %b tag %0d expected 1 tag %0d", i, Iss_ValidAlu, Iss_RobTagAlu, exp_order[i]); end
      step();
    end
    checks++; if (Iss_ValidAlu !== 1'b0 || Iss_IntQueueFull !== 1'b0) begin errors++; $display("FAIL full_drained: got valid %b full %b expected 0 0", Iss_ValidAlu, Iss_IntQueueFull); end
    $display("full/compaction done");
  endtask

  task automatic test_flush();
    logic [4:0] tags [4] = '{5'd31, 5'd0, 5'd2, 5'd4};
    Rob_TopPtr = 5'd30;
    for (int i = 0; i < 4; i++) begin
      set_dis(tags[i], 6'(40 + i), 6'd60, 0, 1);
      step();
    end
    set_dis(5'd5, 6'd1, 6'd1, 1, 1);
    Cdb_Flush = 1; Cdb_RobDepth = 5'd3; Wb_Valid = 1; Wb_PhyAddr = 6'd40; #1;
    checks++; if (Iss_ValidAlu !== 1'b0) begin errors++; $display("FAIL flush_no_issue: got %b expected 0", Iss_ValidAlu); end
    step();
    idle(); Cdb_Flush = 0; Wb_Valid = 0; #1;
    checks++; if (Iss_ValidAlu !== 1'b1 || Iss_RobTagAlu !== 5'd31) begin errors++; $display("FAIL flush_survivor_wake: got valid %b tag %0d expected 1 31", Iss_ValidAlu, Iss_RobTagAlu); end
    step();
    checks++; if (Iss_ValidAlu !== 1'b0) begin errors++; $display("FAIL flush_no_dispatch: got %b expected 0", Iss_ValidAlu); end
    Wb_Valid = 1; Wb_PhyAddr = 6'd41;
    step();
    Wb_Valid = 0; #1;
    checks++; if (Iss_ValidAlu !== 1'b1 || Iss_RobTagAlu !== 5'd0) begin errors++; $display("FAIL flush_keep_tag0: got valid %b tag %0d expected 1 0", Iss_ValidAlu, Iss_RobTagAlu); end
    step();
    Wb_Valid = 1; Wb_PhyAddr = 6'd42;
    step();
    Wb_Valid = 0; Wb_PhyAddr = 6'd43;
    Wb_Valid = 1;
    step();
    Wb_Valid = 0; #1;
    checks++; if (Iss_ValidAlu !== 1'b0) begin errors++; $display("FAIL flush_removed: got valid %b tag %0d expected 0", Iss_ValidAlu, Iss_RobTagAlu); end
    Rob_TopPtr = 5'd0;
    $display("flush done");
  endtask

  task automatic test_stall();
    Alu_Stall = 1;
    set_dis(5'd12, 6'd3, 6'd4, 1, 1);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (Iss_ValidAlu !== 1'b0 || Iss_RobTagAlu !== 5'd12) begin errors++; $display("FAIL stall_hold_%0d: got valid %b tag %0d expected 0 12", i, Iss_ValidAlu, Iss_RobTagAlu); end
      step();
    end
    Alu_Stall = 0; #1;
    checks++; if (Iss_ValidAlu !== 1'b1 || Iss_RobTagAlu !== 5'd12) begin errors++; $display("FAIL stall_release: got valid %b tag %0d expected 1 12", Iss_ValidAlu, Iss_RobTagAlu); end
    step();
    checks++; if (Iss_ValidAlu !== 1'b0) begin errors++; $display("FAIL stall_empty: got %b expected 0", Iss_ValidAlu); end
    $display("stall done");
  endtask

  task automatic test_dispatch_wake();
    set_dis(5'd13, 6'd50, 6'd51, 0, 1);
    Wb_Valid = 1; Wb_PhyAddr = 6'd50;
    step();
    idle(); Wb_Valid = 0; #1;
    checks++; if (Iss_ValidAlu !== 1'b1 || Iss_RobTagAlu !== 5'd13) begin errors++; $display("FAIL dispatch_wake: got valid %b tag %0d expected 1 13", Iss_ValidAlu, Iss_RobTagAlu); end
    step();
    $display("dispatch-time wakeup done");
  endtask

  task automatic test_reset_mid();
    set_dis(5'd14, 6'd5, 6'd6, 1, 1);
    step();
    idle(); #1;
    checks++; if (Iss_ValidAlu !== 1'b1 || Iss_RobTagAlu !== 5'd14) begin errors++; $display("FAIL mid_pre: got valid %b tag %0d expected 1 14", Iss_ValidAlu, Iss_RobTagAlu); end
    Reset = 1; #1;
    checks++; if (Iss_ValidAlu !== 1'b0 || Iss_RobTagAlu !== 5'd0 || Iss_RsPhyAddrAlu !== 6'd0) begin errors++; $display("FAIL mid_async_clear: got valid %b tag %0d rs %0d expected 0 0 0", Iss_ValidAlu, Iss_RobTagAlu, Iss_RsPhyAddrAlu); end
    step();
    Reset = 0;
    step();
    checks++; if (Iss_ValidAlu !== 1'b0 || Iss_IntQueueFull !== 1'b0) begin errors++; $display("FAIL mid_after: got valid %b full %b expected 0 0", Iss_ValidAlu, Iss_IntQueueFull); end
    $display("mid-operation reset done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_wakeup_order();
    test_full();
    test_flush();
    test_stall();
    test_dispatch_wake();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
